// File: rtl/calc_pkg.sv
// Shared widths, divider states and constants for the calculator datapath.
// Imported by the divider top and its step unit.
package calc_pkg;

  localparam int CALC_DW = 8;
  localparam int CALC_VW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Quotient reported for a zero divisor.
  localparam logic [CALC_DW-1:0] CALC_DZ_QUO = '1;

endpackage

// File: rtl/divider_step_unit.sv
// One restoring-division step: shift in a dividend bit,
// try the subtract, keep it or restore.
import calc_pkg::*;

module divider_step_unit #(
  parameter int VW = CALC_VW
) (
  input  logic [VW:0]   part,
  input  logic          din,
  input  logic [VW-1:0] dvs,
  output logic [VW:0]   part_nxt,
  output logic          qbit
);

  logic [VW+1:0] shifted;
  logic [VW+1:0] trial;

  // Extra top bit keeps the trial sign even if the partial overflows.
  always_comb begin
    shifted  = {part, din};
    trial    = shifted - {2'b00, dvs};
    qbit     = ~trial[VW+1];
    part_nxt = qbit ? trial[VW:0] : shifted[VW:0];
  end

endmodule

// File: rtl/divider_8by4_seq.sv
// Sequential restoring divider, one quotient bit per clock.
// DIVIDER_ZERO_FAST_EN: zero divisor skips straight to DONE.
import calc_pkg::*;

module divider_8by4_seq #(
  parameter int DW = CALC_DW,
  parameter int VW = CALC_VW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quo,
  output logic [VW-1:0] rem,
  output logic          dz
);

  localparam int CW = $clog2(DW + 1);

  div_state_t    state;
  div_state_t    state_nxt;
  logic [CW-1:0] cnt;
  logic [VW:0]   part;
  logic [DW-1:0] shreg;
  logic [VW-1:0] dvs_q;
  logic [VW-1:0] dvd_lo;
  logic [DW-1:0] quo_q;
  logic [VW-1:0] rem_q;
  logic          dz_q;

  logic [VW:0]   part_nxt;
  logic          qbit;
  logic          accept;
  logic          last;
  logic          zfast;

  divider_step_unit #(
    .VW(VW)
  ) u_step (
    .part     (part),
    .din      (shreg[DW-1]),
    .dvs      (dvs_q),
    .part_nxt (part_nxt),
    .qbit     (qbit)
  );

  assign accept = start && (state != RUN);
  assign last   = (state == RUN) && (cnt == CW'(1));

`ifdef DIVIDER_ZERO_FAST_EN
  assign zfast = accept && (divisor == '0);
`else
  assign zfast = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: start is only honoured outside RUN.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: begin
        if (!start)     state_nxt = IDLE;
        else if (zfast) state_nxt = DONE;
        else            state_nxt = RUN;
      end
      RUN: begin
        if (cnt == CW'(1)) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture and iteration registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      part   <= '0;
      shreg  <= '0;
      dvs_q  <= '0;
      dvd_lo <= '0;
    end else if (accept) begin
      part   <= '0;
      shreg  <= dividend;
      dvs_q  <= divisor;
      dvd_lo <= dividend[VW-1:0];
      cnt    <= zfast ? '0 : CW'(DW);
    end else if (state == RUN) begin
      part   <= part_nxt;
      shreg  <= {shreg[DW-2:0], qbit};
      cnt    <= cnt - CW'(1);
    end
  end

  // Result registers, updated only on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q <= '0;
      rem_q <= '0;
      dz_q  <= 1'b0;
    end else if (zfast) begin
      quo_q <= DW'(CALC_DZ_QUO);
      rem_q <= dividend[VW-1:0];
      dz_q  <= 1'b1;
    end else if (last) begin
      if (dvs_q == '0) begin
        quo_q <= DW'(CALC_DZ_QUO);
        rem_q <= dvd_lo;
        dz_q  <= 1'b1;
      end else begin
        quo_q <= {shreg[DW-2:0], qbit};
        rem_q <= part_nxt[VW-1:0];
        dz_q  <= 1'b0;
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign quo  = quo_q;
  assign rem  = rem_q;
  assign dz   = dz_q;

endmodule

// File: tb/tb_divider_8by4_seq.sv
// Self-checking bench for divider_8by4_seq.
// Vector table, hand sequences and a full operand sweep.
module tb_divider_8by4_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quo;
  logic [3:0] rem;
  logic       dz;

  int n_chk  = 0;
  int n_fail = 0;

`ifdef DIVIDER_ZERO_FAST_EN
  localparam int ZLAT = 0;
`else
  localparam int ZLAT = 8;
`endif

  typedef struct {
    logic [7:0] a;
    logic [3:0] b;
    logic [7:0] eq;
    logic [3:0] er;
    logic       ez;
  } vec_t;

  vec_t tbl[9];

  divider_8by4_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .quo      (quo),
    .rem      (rem),
    .dz       (dz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic void model(input logic [7:0] a, input logic [3:0] b,
                                output logic [7:0] q, output logic [3:0] r,
                                output logic z);
    int ai;
    int bi;
    ai = int'(a);
    bi = int'(b);
    if (bi == 0) begin
      q = 8'hFF;
      r = a[3:0];
      z = 1'b1;
    end else begin
      q = 8'(ai / bi);
      r = 4'(ai % bi);
      z = 1'b0;
    end
  endfunction

  // Called just after a clock edge with the DUT outside RUN.
  task automatic run_op(input logic [7:0] a, input logic [3:0] b,
                        input logic [7:0] eq, input logic [3:0] er,
                        input logic ez, input bit noise, input string tag);
    int lat;
    lat = 0;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (done !== 1'b1 && lat < 20) begin
      if (noise) begin
        dividend = 8'($urandom);
        divisor  = 4'($urandom);
        start    = 1'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    chk({tag, " latency"}, lat, (b == 4'd0) ? ZLAT : 8);
    chk({tag, " quo"}, quo, eq);
    chk({tag, " rem"}, rem, er);
    chk({tag, " dz"}, dz, ez);
    if (b != 4'd0) begin
      chk({tag, " identity"}, int'(quo) * int'(b) + int'(rem), int'(a));
      chk({tag, " rem<div"}, rem < b, 1);
    end
    @(posedge clk); #1;
    chk({tag, " done width"}, done, 0);
  endtask

  initial begin
    int lat;
    int pulses;
    int first;
    int off;
    logic [7:0] eq;
    logic [3:0] er;
    logic       ez;

    tbl[0] = '{8'd200, 4'd7,  8'd28,  4'd4,  1'b0};
    tbl[1] = '{8'd255, 4'd1,  8'd255, 4'd0,  1'b0};
    tbl[2] = '{8'd5,   4'd9,  8'd0,   4'd5,  1'b0};
    tbl[3] = '{8'd77,  4'd0,  8'd255, 4'd13, 1'b1};
    tbl[4] = '{8'd0,   4'd5,  8'd0,   4'd0,  1'b0};
    tbl[5] = '{8'd15,  4'd15, 8'd1,   4'd0,  1'b0};
    tbl[6] = '{8'd255, 4'd15, 8'd17,  4'd0,  1'b0};
    tbl[7] = '{8'd128, 4'd2,  8'd64,  4'd0,  1'b0};
    tbl[8] = '{8'd0,   4'd0,  8'd255, 4'd0,  1'b1};

    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset quo", quo, 0);
    chk("reset rem", rem, 0);
    chk("reset dz", dz, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++)
      run_op(tbl[i].a, tbl[i].b, tbl[i].eq, tbl[i].er, tbl[i].ez, 0,
             $sformatf("vec%0d", i));

    // Start pulses with other operands while running are ignored.
    dividend = 8'd200;
    divisor  = 4'd7;
    start    = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    pulses = 0;
    first  = 0;
    for (int c = 1; c <= 14; c++) begin
      if (c >= 2 && c <= 5) begin
        start    = 1'b1;
        dividend = 8'd100;
        divisor  = 4'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done === 1'b1) begin
        pulses++;
        if (first == 0) first = c;
      end
    end
    chk("ignore pulses", pulses, 1);
    chk("ignore latency", first, 8);
    chk("ignore quo", quo, 28);
    chk("ignore rem", rem, 4);

    // Back-to-back: restart on the DONE cycle.
    dividend = 8'd0;
    divisor  = 4'd5;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat   = 0;
    while (done !== 1'b1 && lat < 20) begin
      chk("b2b busy in run", busy, 1);
      @(posedge clk); #1;
      lat++;
    end
    chk("b2b first latency", lat, 8);
    chk("b2b first quo", quo, 0);
    chk("b2b first rem", rem, 0);
    chk("b2b busy on done", busy, 0);
    dividend = 8'd15;
    divisor  = 4'd15;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b busy restart", busy, 1);
    chk("b2b done restart", done, 0);
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("b2b second latency", lat, 8);
    chk("b2b second quo", quo, 1);
    chk("b2b second rem", rem, 0);
    chk("b2b second dz", dz, 0);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of an operation.
    dividend = 8'd200;
    divisor  = 4'd7;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst quo", quo, 0);
    chk("midrst rem", rem, 0);
    chk("midrst dz", dz, 0);
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    chk("midrst no activity", pulses, 0);

    // Every operand pair, in a scrambled order, with noisy inputs.
    off = int'($urandom_range(0, 4095));
    for (int k = 0; k < 4096; k++) begin
      int p;
      logic [7:0] a;
      logic [3:0] b;
      p = (k * 1237 + off) % 4096;
      a = 8'(p >> 4);
      b = 4'(p);
      model(a, b, eq, er, ez);
      run_op(a, b, eq, er, ez, 1, "sweep");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
